// File: rtl/ex_cond_stage.sv
// Execute-stage condition evaluation, NZCV flag register, side-effect gating,
// E->M pipeline register and taken-branch squash FSM. EX_PERF_CNT_EN adds perf counters.
module ex_cond_stage #(
  parameter int WIDTH        = 32,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       ALUFlagsE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       WA3E,
  input  logic             StallM,
  input  logic             FlushM,
  output logic             BranchTakenE,
  output logic             CondExE,
  output logic [3:0]       FlagsQ,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic [31:0]      BranchCntQ,
  output logic [31:0]      SquashCntQ
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_e;

  typedef struct packed {
    logic             pcsrc;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic [3:0]       wa3;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wd;
  } em_t;

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  em_t        em_q, em_d;
  logic       cond_met, kill;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_met = 1'b1;
    case (CondE)
      4'h0:    cond_met = z;
      4'h1:    cond_met = ~z;
      4'h2:    cond_met = c;
      4'h3:    cond_met = ~c;
      4'h4:    cond_met = n;
      4'h5:    cond_met = ~n;
      4'h6:    cond_met = v;
      4'h7:    cond_met = ~v;
      4'h8:    cond_met = c & ~z;
      4'h9:    cond_met = ~c | z;
      4'hA:    cond_met = (n == v);
      4'hB:    cond_met = (n != v);
      4'hC:    cond_met = ~z & (n == v);
      4'hD:    cond_met = z | (n != v);
      default: cond_met = 1'b1;
    endcase
  end

  assign CondExE      = cond_met & (state_q == RUN);
  assign BranchTakenE = (BranchE | PCSrcE) & CondExE & ~StallM;
  assign kill         = (state_q == SQUASH) & ~StallM;

  // Flags only move for executing, non-stalled instructions; no bypass to E.
  always_comb begin
    flags_d = flags_q;
    if (CondExE && !StallM) begin
      if (FlagWriteE[1]) flags_d[3:2] = ALUFlagsE[3:2];
      if (FlagWriteE[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end
  end

  // Stall outranks flush; failed/killed instructions lose their side effects.
  always_comb begin
    em_d = em_q;
    if (!StallM) begin
      if (FlushM) begin
        em_d = '0;
      end else begin
        em_d.pcsrc    = PCSrcE & CondExE;
        em_d.regwrite = RegWriteE & CondExE;
        em_d.memtoreg = MemtoRegE;
        em_d.memwrite = MemWriteE & CondExE;
        em_d.wa3      = WA3E;
        em_d.alu      = ALUResultE;
        em_d.wd       = WriteDataE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (BranchTakenE) begin
          state_d = SQUASH;
          cnt_d   = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (!StallM) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      flags_q <= '0;
      em_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      em_q    <= em_d;
    end
  end

  assign FlagsQ     = flags_q;
  assign PCSrcM     = em_q.pcsrc;
  assign RegWriteM  = em_q.regwrite;
  assign MemtoRegM  = em_q.memtoreg;
  assign MemWriteM  = em_q.memwrite;
  assign WA3M       = em_q.wa3;
  assign ALUOutM    = em_q.alu;
  assign WriteDataM = em_q.wd;

`ifdef EX_PERF_CNT_EN
  logic [31:0] bcnt_q, bcnt_d, scnt_q, scnt_d;

  always_comb begin
    bcnt_d = bcnt_q + {31'd0, BranchTakenE};
    scnt_d = scnt_q + {31'd0, kill};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign BranchCntQ = bcnt_q;
  assign SquashCntQ = scnt_q;
`else
  logic unused_kill;
  assign unused_kill = kill;
  assign BranchCntQ  = '0;
  assign SquashCntQ  = '0;
`endif

endmodule

// File: tb/tb_ex_cond_stage.sv
// Randomized bench for ex_cond_stage against a cycle-level behavioural model,
// plus directed scenarios with fixed expected values.
module tb_ex_cond_stage;
  localparam int W  = 32;
  localparam int SD = 2;
`ifdef EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, StallM, FlushM;
  logic [1:0] FlagWriteE;
  logic [3:0] CondE, ALUFlagsE, WA3E;
  logic [W-1:0] ALUResultE, WriteDataE;
  logic BranchTakenE, CondExE, PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0] FlagsQ, WA3M;
  logic [W-1:0] ALUOutM, WriteDataM;
  logic [31:0] BranchCntQ, SquashCntQ;

  ex_cond_stage #(.WIDTH(W), .SQUASH_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .FlagWriteE(FlagWriteE), .CondE(CondE), .ALUFlagsE(ALUFlagsE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .StallM(StallM), .FlushM(FlushM), .BranchTakenE(BranchTakenE),
    .CondExE(CondExE), .FlagsQ(FlagsQ), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WA3M(WA3M), .BranchCntQ(BranchCntQ),
    .SquashCntQ(SquashCntQ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: flags, remaining wrong-path slots, M register, counters.
  logic [3:0]   m_fl;
  int           m_sq;
  logic [3:0]   m_ctl;  // {PCSrc, RegWrite, MemtoReg, MemWrite}
  logic [3:0]   m_wa3;
  logic [W-1:0] m_alu, m_wd;
  logic [31:0]  m_bc, m_sc;

  // Conditions come in complementary pairs; odd codes invert the even one.
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (cc[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: return 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic model_clear();
    m_fl = '0; m_sq = 0; m_ctl = '0; m_wa3 = '0; m_alu = '0; m_wd = '0;
    m_bc = '0; m_sc = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".ctlM"}, {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, m_ctl);
    chk({tag, ".aluM"}, ALUOutM, m_alu);
    chk({tag, ".wdM"}, WriteDataM, m_wd);
    chk({tag, ".wa3M"}, WA3M, m_wa3);
    chk({tag, ".flags"}, FlagsQ, m_fl);
    chk({tag, ".bcnt"}, BranchCntQ, PERF ? m_bc : 32'd0);
    chk({tag, ".scnt"}, SquashCntQ, PERF ? m_sc : 32'd0);
  endtask

  task automatic drive(input logic pcs, input logic rw, input logic m2r, input logic mw,
                       input logic br, input logic [1:0] fw, input logic [3:0] cond,
                       input logic [3:0] af, input logic st, input logic fl);
    PCSrcE = pcs; RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw; BranchE = br;
    FlagWriteE = fw; CondE = cond; ALUFlagsE = af; StallM = st; FlushM = fl;
    ALUResultE = $urandom; WriteDataE = $urandom; WA3E = 4'($urandom_range(0, 15));
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic cyc(input string tag);
    logic ce, bt;
    #1;
    ce = cond_ok(CondE, m_fl) && (m_sq == 0);
    bt = (BranchE || PCSrcE) && ce && !StallM;
    chk({tag, ".condex"}, CondExE, ce);
    chk({tag, ".brtaken"}, BranchTakenE, bt);
    @(posedge clk);
    if (!StallM) begin
      if (ce) begin
        if (FlagWriteE[1]) m_fl[3:2] = ALUFlagsE[3:2];
        if (FlagWriteE[0]) m_fl[1:0] = ALUFlagsE[1:0];
      end
      if (FlushM) begin
        m_ctl = '0; m_alu = '0; m_wd = '0; m_wa3 = '0;
      end else begin
        m_ctl = {PCSrcE && ce, RegWriteE && ce, MemtoRegE, MemWriteE && ce};
        m_alu = ALUResultE; m_wd = WriteDataE; m_wa3 = WA3E;
      end
      if (m_sq > 0) begin
        m_sq--; m_sc++;
      end else if (bt) begin
        m_sq = SD; m_bc++;
      end
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed away from the clock edges.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_clear();
    check_regs(tag);
    chk({tag, ".condex"}, CondExE, cond_ok(CondE, 4'b0000));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 0);
    model_clear();
    #12;
    check_regs("rst");
    chk("rst.condexAL", CondExE, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0, 0, 0);
    cyc("idle");
    chk("idle.rw", RegWriteM, 1'b0);

    // Z set by an ADD, then EQ executes and NE does not.
    drive(0, 1, 0, 0, 0, 2'b11, 4'hE, 4'b0100, 0, 0); cyc("add");
    drive(0, 1, 0, 0, 0, 2'b00, 4'h0, 4'b1011, 0, 0); cyc("eq");
    chk("eq.flags", FlagsQ, 4'b0100);
    chk("eq.rw", RegWriteM, 1'b1);
    drive(0, 1, 0, 0, 0, 2'b11, 4'h1, 4'b1011, 0, 0); cyc("ne");
    chk("ne.rw", RegWriteM, 1'b0);
    chk("ne.flags", FlagsQ, 4'b0100);

    // Taken branch kills exactly two following stores.
    drive(0, 0, 0, 0, 1, 2'b00, 4'hE, 4'h0, 0, 0); cyc("br");
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 2'b00, 4'hE, 4'h0, 0, 0); cyc("brk");
      chk("brk.mw", MemWriteM, 1'b0);
      chk("brk.bt", BranchTakenE, 1'b0);
    end
    drive(0, 0, 0, 1, 0, 2'b00, 4'hE, 4'h0, 0, 0); cyc("br3");
    chk("br3.mw", MemWriteM, 1'b1);

    // Stall during squash freezes the count; two kills follow release.
    drive(0, 0, 0, 0, 1, 2'b00, 4'hE, 4'h0, 0, 0); cyc("sbr");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 2'b00, 4'hE, 4'h0, 1, 0); cyc("stl");
      chk("stl.condex", CondExE, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 1, 0, 2'b00, 4'hE, 4'h0, 0, 0); cyc("skill");
      chk("skill.ctl", {RegWriteM, MemWriteM}, 2'b00);
    end
    drive(0, 1, 0, 1, 0, 2'b00, 4'hE, 4'h0, 0, 0); cyc("srun");
    chk("srun.ctl", {RegWriteM, MemWriteM}, 2'b11);

    // Stall beats flush; flush alone bubbles.
    drive(0, 1, 1, 0, 0, 2'b00, 4'hE, 4'h0, 0, 0); cyc("f0");
    drive(0, 0, 0, 0, 0, 2'b00, 4'hE, 4'h0, 1, 1); cyc("fst");
    chk("fst.rw", RegWriteM, 1'b1);
    drive(0, 1, 1, 1, 0, 2'b00, 4'hE, 4'h0, 0, 1); cyc("fl");
    chk("fl.ctl", {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 4'b0000);

    // Three branches, then reset mid-squash.
    pulse_reset("prst");
    for (int b = 0; b < 3; b++) begin
      drive(0, 0, 0, 0, 1, 2'b00, 4'hE, 4'h0, 0, 0); cyc("pbr");
      for (int i = 0; i < SD; i++) begin
        drive(0, 0, 0, 0, 1, 2'b00, 4'hE, 4'h0, 0, 0); cyc("pk");
      end
    end
    chk("perf.bcnt", BranchCntQ, PERF ? 32'd3 : 32'd0);
    chk("perf.scnt", SquashCntQ, PERF ? 32'd6 : 32'd0);
    drive(0, 0, 0, 0, 1, 2'b00, 4'hE, 4'h0, 0, 0); cyc("mbr");
    drive(0, 1, 0, 1, 0, 2'b00, 4'hE, 4'h0, 0, 0);
    pulse_reset("mrst");
    chk("mrst.bcnt", BranchCntQ, 32'd0);
    drive(0, 1, 0, 1, 0, 2'b00, 4'hE, 4'h0, 0, 0); cyc("mrun");
    chk("mrun.mw", MemWriteM, 1'b1);

    // Random traffic with occasional stalls, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 11) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 5) == 0, 2'($urandom), 4'($urandom), 4'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset("rrst");
      else cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_cond_stage.md
Name: ex_cond_stage

Overview:
- Execute-side consumer of the decode/execute pipeline register outputs (PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE, CondE).
- Holds the architectural NZCV flags and evaluates CondE against them.
- Gates side effects of failed or squashed instructions, then registers surviving controls and data into the execute/memory pipeline register.
- Issues a one-cycle branch-taken redirect and kills the SQUASH_DEPTH wrong-path instructions that reach execute after it.

Parameters:
- WIDTH, 32, datapath width of ALU result and store data.
- SQUASH_DEPTH, 2, number of wrong-path instructions killed in E after a taken redirect (1..7).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- PCSrcE  in  1  instruction writes PC via register write.
- RegWriteE  in  1  register write request.
- MemtoRegE  in  1  writeback selects memory data.
- MemWriteE  in  1  store request.
- BranchE  in  1  branch instruction.
- FlagWriteE  in  2  bit1 updates N,Z; bit0 updates C,V.
- CondE  in  4  ARM-style condition field.
- ALUFlagsE  in  4  {N,Z,C,V} from the ALU this cycle.
- ALUResultE  in  WIDTH  ALU result.
- WriteDataE  in  WIDTH  store data.
- WA3E  in  4  destination register.
- StallM  in  1  hold E->M register, flags and squash state.
- FlushM  in  1  load a bubble into E->M register.
- BranchTakenE  out  1  combinational redirect request to fetch and hazard logic.
- CondExE  out  1  combinational: E instruction executes.
- FlagsQ  out  4  current {N,Z,C,V}.
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered controls.
- ALUOutM  out  WIDTH  registered ALU result.
- WriteDataM  out  WIDTH  registered store data.
- WA3M  out  4  registered destination.
- BranchCntQ, SquashCntQ  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset, asynchronous with reset=0: all M outputs 0, FlagsQ=0000, squash count 0 (state RUN), counters 0. Combinational outputs follow from these values.
- Condition met (CondMet) per CondE:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V). E AL: 1. F: 1.
- CondExE = CondMet & (state==RUN).
- BranchTakenE = (BranchE | PCSrcE) & CondExE & !StallM. It is a single-cycle pulse and is never asserted while stalled.
- Flags update at the clock edge only when CondExE & !StallM:
  - FlagWriteE[1]: N,Z <= ALUFlagsE[3:2].
  - FlagWriteE[0]: C,V <= ALUFlagsE[1:0].
  - Flags are never bypassed; the next instruction in E sees the registered value.
- E->M register, in priority order:
  - StallM=1: hold everything, including when FlushM=1.
  - FlushM=1: load a bubble (all controls 0, data 0).
  - Otherwise: RegWriteM<=RegWriteE&CondExE, MemWriteM<=MemWriteE&CondExE, PCSrcM<=PCSrcE&CondExE; MemtoRegM, ALUOutM, WriteDataM, WA3M load unconditionally.
- Latency: 1 cycle from E inputs to M outputs.
- Squash FSM, state RUN when count=0, SQUASH when count>0:
  - RUN: when BranchTakenE=1, count<=SQUASH_DEPTH.
  - SQUASH: each non-stalled cycle decrements count and kills the E instruction. Branches in killed slots are ignored, so no reload occurs.
  - StallM=1 freezes the count.
  - FlushM has no effect on the count.
- Reset asserted mid-squash returns the FSM to RUN immediately.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- Defined: BranchCntQ increments on each BranchTakenE pulse; SquashCntQ increments on each non-stalled killed cycle. Both are 32-bit, wrap at 2^32-1 to 0, and are cleared by reset.
- Undefined: both ports are driven constant 0 and no counter registers are inferred.

Test Plan:
- Reset then release, no stimulus -> all M outputs 0, FlagsQ=0000, CondExE=1 for CondE=E.
- ADD with FlagWriteE=11, ALUFlagsE=0100, CondE=E; next instruction CondE=0 (EQ) with RegWriteE=1 -> FlagsQ=0100, RegWriteM=1; with CondE=1 (NE) instead -> RegWriteM=0, flags unchanged.
- Branch CondE=E, SQUASH_DEPTH=2, followed by two stores (MemWriteE=1) -> BranchTakenE high exactly 1 cycle; both stores give MemWriteM=0; third instruction executes normally.
- Taken branch, then StallM=1 for 3 cycles during squash -> count frozen; exactly 2 instructions killed after the stall releases; outputs held during the stall.
- StallM=1 and FlushM=1 together with RegWriteM=1 registered -> RegWriteM stays 1; next cycle with FlushM only -> bubble (all controls 0).
- With EX_PERF_CNT_EN defined: 3 taken branches -> BranchCntQ=3, SquashCntQ=6; reset=0 mid-sequence -> both 0. Undefined: both read 0 throughout.
